lsu: RTL

Load/store unit between the core's ALU/register-file datapath and a handshaked data memory port. It turns one RV32I load or store per request into a word-aligned memory transaction with byte enables, stalls the core until the transaction completes, and returns sign- or zero-extended load data to the write-back mux. Misaligned accesses, illegal `FUNC3` codes and memory timeouts are reported as a one-cycle error and never reach memory.

---
 rtl/lsu.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// RV32I load/store unit: turns one core load/store into a word-aligned, byte-enabled
// memory transaction, stalls the core until it completes, and returns extended load data.
module lsu #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic        WE,
    input  logic [2:0]  FUNC3,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic        STALL,
    output logic        DONE,
    output logic        ERR,
    output logic [31:0] RDATA,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [3:0]  MEM_BE,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_GNT,
    input  logic        MEM_RVALID,
    input  logic [31:0] MEM_RDATA
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  func3_q, func3_d;
    logic [1:0]  off_q, off_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        func_ok, misaligned, legal;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  cnt_inc;
    logic        timeout_hit;
    logic [31:0] lane;
    logic [31:0] ext;

    // Request decode: legality, byte enables and lane-replicated store data.
    always_comb begin
        func_ok    = WE ? (FUNC3 < 3'd3) : !(FUNC3 == 3'd3 || FUNC3[2:1] == 2'b11);
        misaligned = (FUNC3[1:0] == 2'd1 && ADDR[0]) ||
                     (FUNC3[1:0] == 2'd2 && ADDR[1:0] != 2'b00);
        legal      = func_ok && !misaligned;
        case (FUNC3[1:0])
            2'd0: begin
                be_new    = 4'b0001 << ADDR[1:0];
                wdata_new = {4{WDATA[7:0]}};
            end
            2'd1: begin
                be_new    = 4'b0011 << ADDR[1:0];
                wdata_new = {2{WDATA[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = WDATA;
            end
        endcase
    end

    assign cnt_inc     = cnt_q + 8'd1;
    assign timeout_hit = (cnt_inc == 8'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        func3_d = func3_q;
        off_d   = off_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (REQ) begin
                    we_d    = WE;
                    func3_d = FUNC3;
                    off_d   = ADDR[1:0];
                    be_d    = be_new;
                    addr_d  = {ADDR[31:2], 2'b00};
                    wdata_d = wdata_new;
                    cnt_d   = 8'd0;
                    err_d   = !legal;
                    state_d = legal ? StReq : StDone;
                end
            end
            StReq: begin
                cnt_d = cnt_inc;
                // A real completion wins over a timeout landing in the same cycle.
                if (MEM_GNT && MEM_RVALID) begin
                    rdata_d = MEM_RDATA;
                    state_d = StDone;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else if (MEM_GNT) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_inc;
                if (MEM_RVALID) begin
                    rdata_d = MEM_RDATA;
                    state_d = StDone;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            func3_q <= 3'd0;
            off_q   <= 2'd0;
            be_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            func3_q <= func3_d;
            off_q   <= off_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign lane = rdata_q >> {off_q, 3'b000};

    always_comb begin
        case (func3_q)
            3'd0:    ext = {{24{lane[7]}}, lane[7:0]};
            3'd1:    ext = {{16{lane[15]}}, lane[15:0]};
            3'd2:    ext = lane;
            3'd4:    ext = {24'd0, lane[7:0]};
            3'd5:    ext = {16'd0, lane[15:0]};
            default: ext = 32'd0;
        endcase
    end

    // STALL is gated by RESET so it is low during reset even with REQ held high.
    assign STALL     = RESET && ((state_q == StIdle && REQ) || state_q == StReq ||
                                 state_q == StWait);
    assign MEM_REQ   = (state_q == StReq);
    assign MEM_WE    = MEM_REQ && we_q;
    assign MEM_ADDR  = MEM_REQ ? addr_q : 32'd0;
    assign MEM_BE    = MEM_REQ ? be_q : 4'd0;
    assign MEM_WDATA = MEM_REQ ? wdata_q : 32'd0;
    assign DONE      = (state_q == StDone);
    assign ERR       = DONE && err_q;
    assign RDATA     = (DONE && !we_q && !err_q) ? ext : 32'd0;

endmodule
